// File: rtl/fizzbuzz_pkg.sv
// Shared constants for the fizzbuzz sequencer: register map, CTRL/STATUS bits,
// result flag bits and engine state encoding.
package fizzbuzz_pkg;

  localparam logic [2:0] ADDR_START   = 3'd0;
  localparam logic [2:0] ADDR_COUNT   = 3'd1;
  localparam logic [2:0] ADDR_DIVA    = 3'd2;
  localparam logic [2:0] ADDR_DIVB    = 3'd3;
  localparam logic [2:0] ADDR_CTRL    = 3'd4;
  localparam logic [2:0] ADDR_RESULT  = 3'd5;
  localparam logic [2:0] ADDR_HEADNUM = 3'd6;

  // CTRL write bits
  localparam int CTRL_GO      = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_CLRDONE = 3;

  // STATUS read bits
  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_IE    = 2;
  localparam int ST_EMPTY = 3;
  localparam int ST_FULL  = 4;
  localparam int ST_LVL_LO = 8;

  localparam int FLAG_A  = 0;
  localparam int FLAG_B  = 1;
  localparam int FLAG_AB = 2;

  typedef enum logic [1:0] {IDLE, DIVIDE, RUN} state_t;

endpackage

// File: rtl/fizzbuzz_fifo.sv
// Synchronous result FIFO with flush; flush dominates push and pop.
module fizzbuzz_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp, r_rp;
  logic             w_do_push, w_do_pop;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_level   = r_wp - r_rp;
  assign o_dout    = r_mem[r_rp[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_do_pop)  r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wp[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/fizzbuzz_seq_io.sv
// Avalon-MM fizzbuzz sequencer: serial-divide the start value once, then emit
// one {number, flags} per cycle into a result FIFO. Optional FIZZBUZZ_IRQ_EN.
module fizzbuzz_seq_io
  import fizzbuzz_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int DIV_WIDTH    = 8,
  parameter int DEFAULT_DIVA = 3,
  parameter int DEFAULT_DIVB = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int FW  = WIDTH + 3;
  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int SW  = $clog2(WIDTH);
  localparam int DW1 = DIV_WIDTH + 1;

  logic [WIDTH-1:0]     r_start, r_n, r_shift;
  logic [15:0]          r_count, r_left;
  logic [DIV_WIDTH-1:0] r_diva, r_divb, r_da, r_db, r_ra, r_rb;
  logic [SW-1:0]        r_step;
  logic                 r_ie, r_done;
  state_t               r_state;

  logic          w_go, w_abort, w_clrdone, w_push, w_pop;
  logic          w_full, w_empty, w_fa, w_fb;
  logic [2:0]    w_flags;
  logic [FW-1:0] w_head;
  logic [LW-1:0] w_level;
  logic [WIDTH-1:0] w_n_inc;
  logic [31:0]   w_rd;

  function automatic logic [DIV_WIDTH-1:0] div_step(logic [DIV_WIDTH-1:0] r, logic b,
                                                    logic [DIV_WIDTH-1:0] d);
    logic [DIV_WIDTH:0] s;
    s = {r, b};
    return (s >= {1'b0, d}) ? DIV_WIDTH'(s - {1'b0, d}) : s[DIV_WIDTH-1:0];
  endfunction

  function automatic logic [DIV_WIDTH-1:0] rem_inc(logic [DIV_WIDTH-1:0] r,
                                                   logic [DIV_WIDTH-1:0] d);
    logic [DIV_WIDTH:0] p;
    p = {1'b0, r} + DW1'(1);
    return (p == {1'b0, d}) ? '0 : p[DIV_WIDTH-1:0];
  endfunction

  assign w_go      = write && (address == ADDR_CTRL) && writedata[CTRL_GO];
  assign w_abort   = write && (address == ADDR_CTRL) && writedata[CTRL_ABORT];
  assign w_clrdone = write && (address == ADDR_CTRL) && writedata[CTRL_CLRDONE];
  assign w_push    = (r_state == RUN) && !w_full;
  assign w_pop     = read && (address == ADDR_RESULT) && !w_empty;
  assign w_n_inc   = r_n + WIDTH'(1);

  // Remainders track n mod divisor exactly, so a zero remainder means divisible.
  assign w_fa    = (r_da != '0) && (r_n != '0) && (r_ra == '0);
  assign w_fb    = (r_db != '0) && (r_n != '0) && (r_rb == '0);
  assign w_flags = {w_fa & w_fb, w_fb, w_fa};

  fizzbuzz_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_abort),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({r_n, w_flags}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start <= '0;
      r_count <= '0;
      r_diva  <= DIV_WIDTH'(DEFAULT_DIVA);
      r_divb  <= DIV_WIDTH'(DEFAULT_DIVB);
      r_ie    <= 1'b0;
      r_done  <= 1'b0;
      r_state <= IDLE;
      r_n     <= '0;
      r_shift <= '0;
      r_left  <= '0;
      r_da    <= '0;
      r_db    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_step  <= '0;
    end else begin
      if (write) begin
        case (address)
          ADDR_START: r_start <= writedata[WIDTH-1:0];
          ADDR_COUNT: r_count <= writedata[15:0];
          ADDR_DIVA:  r_diva  <= writedata[DIV_WIDTH-1:0];
          ADDR_DIVB:  r_divb  <= writedata[DIV_WIDTH-1:0];
          ADDR_CTRL:  r_ie    <= writedata[CTRL_IE];
          default: ;
        endcase
      end
      if (w_clrdone) r_done <= 1'b0;

      case (r_state)
        IDLE: if (w_go) begin
          r_done  <= (r_count == '0);
          r_n     <= r_start;
          r_shift <= r_start;
          r_left  <= r_count;
          r_da    <= r_diva;
          r_db    <= r_divb;
          r_ra    <= '0;
          r_rb    <= '0;
          r_step  <= '0;
          if (r_count != '0) r_state <= DIVIDE;
        end
        DIVIDE: begin
          r_ra    <= div_step(r_ra, r_shift[WIDTH-1], r_da);
          r_rb    <= div_step(r_rb, r_shift[WIDTH-1], r_db);
          r_shift <= r_shift << 1;
          r_step  <= r_step + SW'(1);
          if (r_step == SW'(WIDTH-1)) r_state <= RUN;
        end
        RUN: if (w_push) begin
          r_n    <= w_n_inc;
          r_left <= r_left - 16'd1;
          r_ra   <= (w_n_inc == '0) ? '0 : rem_inc(r_ra, r_da);
          r_rb   <= (w_n_inc == '0) ? '0 : rem_inc(r_rb, r_db);
          if (r_left == 16'd1) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_abort) begin
        r_state <= IDLE;
        r_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd = '0;
    if (read) begin
      case (address)
        ADDR_START: w_rd[WIDTH-1:0]     = r_start;
        ADDR_COUNT: w_rd[15:0]          = r_count;
        ADDR_DIVA:  w_rd[DIV_WIDTH-1:0] = r_diva;
        ADDR_DIVB:  w_rd[DIV_WIDTH-1:0] = r_divb;
        ADDR_CTRL: begin
          w_rd[ST_BUSY]  = (r_state != IDLE);
          w_rd[ST_DONE]  = r_done;
          w_rd[ST_IE]    = r_ie;
          w_rd[ST_EMPTY] = w_empty;
          w_rd[ST_FULL]  = w_full;
          w_rd[ST_LVL_LO+:8] = 8'(w_level);
        end
        ADDR_RESULT: if (!w_empty) begin
          w_rd[31]  = 1'b1;
          w_rd[2:0] = w_head[2:0];
        end
        ADDR_HEADNUM: if (!w_empty) w_rd[WIDTH-1:0] = w_head[FW-1:3];
        default: ;
      endcase
    end
  end
  assign readdata = w_rd;

`ifdef FIZZBUZZ_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= r_ie & r_done;
  end
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fizzbuzz_seq_io.sv
// Scoreboard bench for fizzbuzz_seq_io: reads queue their expected value, a
// negedge monitor pops and compares; results come from an arithmetic model.
module tb_fizzbuzz_seq_io;
  import fizzbuzz_pkg::*;

  localparam int W = 4;
  localparam int D = 16;

  logic        clk = 0, reset = 1, read = 0, write = 0, chk = 0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  fizzbuzz_seq_io #(.WIDTH(W), .DEPTH(D), .DIV_WIDTH(8),
                    .DEFAULT_DIVA(3), .DEFAULT_DIVB(5)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] v; string nm; } exp_t;
  typedef struct { int n; int f; } ent_t;
  exp_t sb[$];
  ent_t mq[$];
  int n_pass = 0, n_total = 0;
  int cur_start = 0, cur_count = 0, cur_da = 3, cur_db = 5;
  bit cur_ie = 0;

  function automatic void compare(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Monitor: every checked read pops one expectation.
  always @(negedge clk) begin
    if (read && chk) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: got %h expected nothing", readdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        compare(e.nm, readdata, e.v);
      end
    end
  end

  function automatic int flags(int n, int a, int b);
    bit fa, fb;
    fa = (a != 0) && (n != 0) && (n % a == 0);
    fb = (b != 0) && (n != 0) && (n % b == 0);
    return int'(fa && fb) * 4 + int'(fb) * 2 + int'(fa);
  endfunction

  function automatic void model_job();
    for (int i = 0; i < cur_count; i++) begin
      ent_t e;
      e.n = (cur_start + i) % (1 << W);
      e.f = flags(e.n, cur_da, cur_db);
      mq.push_back(e);
    end
  endfunction

  function automatic logic [31:0] st(bit busy, bit done, int lvl);
    logic [31:0] s;
    s = '0;
    s[0] = busy; s[1] = done; s[2] = cur_ie;
    s[3] = (lvl == 0); s[4] = (lvl == D);
    s[15:8] = 8'(lvl);
    return s;
  endfunction

  task automatic cyc(int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1;
    @(posedge clk); #1;
    write = 0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] e, input string nm);
    exp_t x;
    x.v = e; x.nm = nm;
    sb.push_back(x);
    address = a; read = 1; chk = 1;
    @(posedge clk); #1;
    read = 0; chk = 0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1; chk = 0;
    @(negedge clk); d = readdata;
    @(posedge clk); #1;
    read = 0;
  endtask

  task automatic wait_ne(output bit ok);
    logic [31:0] s;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      peek(ADDR_CTRL, s);
      ok = !s[3];
    end
    if (!ok) begin
      n_total++;
      $display("FAIL fifo_wait: timed out with %0d entries outstanding, expected data", mq.size());
    end
  endtask

  task automatic drain();
    int k;
    bit ok;
    k = mq.size();
    for (int i = 0; i < k; i++) begin
      ent_t e;
      wait_ne(ok);
      if (!ok) begin mq.delete(); return; end
      e = mq.pop_front();
      rd_chk(ADDR_HEADNUM, 32'(e.n), "headnum");
      rd_chk(ADDR_RESULT, 32'h8000_0000 | 32'(e.f), "result");
    end
  endtask

  task automatic go();
    wr(ADDR_CTRL, (32'(cur_ie) << 2) | 32'h1);
    model_job();
  endtask

  task automatic setup(int s, int c, int a, int b);
    wr(ADDR_START, 32'(s)); cur_start = s;
    wr(ADDR_COUNT, 32'(c)); cur_count = c;
    wr(ADDR_DIVA, 32'(a));  cur_da = a;
    wr(ADDR_DIVB, 32'(b));  cur_db = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    int k;
    bit seen;

    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    compare("rdata_idle", readdata, 32'h0);
    compare("irq_reset", 32'(irq), 32'h0);
    @(posedge clk); #1;
    rd_chk(ADDR_START, 32'h0, "rst_start");
    rd_chk(ADDR_COUNT, 32'h0, "rst_count");
    rd_chk(ADDR_DIVA, 32'h3, "rst_diva");
    rd_chk(ADDR_DIVB, 32'h5, "rst_divb");
    rd_chk(ADDR_CTRL, st(0, 0, 0), "rst_status");
    rd_chk(3'd7, 32'h0, "addr7");
    rd_chk(ADDR_RESULT, 32'h0, "result_empty");

    // Classic 1..15 with default divisors
    setup(1, 15, 3, 5);
    go();
    drain();
    rd_chk(ADDR_CTRL, st(0, 1, 0), "t1_status");

    // Programmable divisors plus first-entry latency
    setup(12, 3, 2, 7);
    wr(ADDR_CTRL, 32'h1);
    model_job();
    k = 1;
    s = 32'h8;
    while (k < 50) begin
      peek(ADDR_CTRL, s);
      if (!s[3]) break;
      k++;
    end
    compare("latency", 32'(k), 32'(W + 2));
    drain();
    rd_chk(ADDR_CTRL, st(0, 1, 0), "t2_status");

    // Back-pressure: FIFO fills, config and GO during run must not disturb the job
    setup(int'($urandom_range(0, 15)), 40, 3, 5);
    go();
    wr(ADDR_DIVA, 32'h7);
    rd_chk(ADDR_DIVA, 32'h7, "diva_busy_wr");
    wr(ADDR_CTRL, 32'h1);
    cyc(30);
    rd_chk(ADDR_CTRL, st(1, 0, D), "t3_full");
    drain();
    rd_chk(ADDR_CTRL, st(0, 1, 0), "t3_status");

    // Number wrap at 2^W
    setup(14, 4, 3, 5);
    go();
    drain();

    // ABORT during DIVIDE, then a clean job
    setup(5, 3, 3, 5);
    wr(ADDR_CTRL, 32'h1);
    cyc(2);
    wr(ADDR_CTRL, 32'h2);
    rd_chk(ADDR_CTRL, st(0, 0, 0), "t5_abort");
    go();
    drain();
    rd_chk(ADDR_CTRL, st(0, 1, 0), "t5_status");

    // Randomised jobs including divisors 0 and 1
    for (int j = 0; j < 6; j++) begin
      setup(int'($urandom_range(0, 15)), int'($urandom_range(1, 24)),
            int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
      go();
      cyc(int'($urandom_range(1, 12)));
      wr(ADDR_START, 32'(j));
      cur_start = j;
      drain();
      rd_chk(ADDR_CTRL, st(0, 1, 0), "rnd_status");
    end

    // COUNT=0 completes immediately; interrupt behaviour
    cur_ie = 1;
    wr(ADDR_COUNT, 32'h0);
    cur_count = 0;
    go();
    seen = 0;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk); seen = irq;
      @(posedge clk); #1;
    end
`ifdef FIZZBUZZ_IRQ_EN
    compare("irq_rise", 32'(seen), 32'h1);
`else
    compare("irq_off", 32'(seen), 32'h0);
`endif
    rd_chk(ADDR_CTRL, st(0, 1, 0), "t6_done");
    wr(ADDR_CTRL, 32'h4 | 32'h8);
    cyc(2);
    @(negedge clk);
    compare("irq_clr", 32'(irq), 32'h0);
    @(posedge clk); #1;
    rd_chk(ADDR_CTRL, st(0, 0, 0), "t6_clrdone");

    cyc(2);
    compare("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
